// File: rtl/dac_reg_spi_sched.sv
// ---------------------------------------------------------------------------
// dac_reg_spi_sched
//
// Shares one 8-bit SPI master between two writers. The mode/mux register
// sends single bytes behind cs2_reg. The DAC sends 16-bit words, MSB byte
// first, behind cs1_dac. A round-robin arbiter picks the next writer. The
// block frames each transaction with chip-select setup, hold and gap times.
// It also aborts a transaction if a byte never completes.
//
// State table
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no transaction; ready offered to the arbitration winner
//   S_SETUP | granted CS low, counting CS_SETUP cycles before first byte
//   S_START | current byte on spi_data; spi_start fires once spi_busy=0
//   S_WAIT  | waiting for spi_new_data; timeout down-counter running
//   S_HOLD  | last byte finished, CS held low for CS_HOLD cycles
//   S_GAP   | both CS high for CS_GAP cycles; done pulse on first cycle
//
// Ports
//   clk, rst                  system clock, async active-low reset
//   reg_valid/reg_data        register write request (8 bit)
//   reg_ready/reg_done        accept strobe / completion pulse
//   dac_valid/dac_data        DAC write request (16 bit)
//   dac_ready/dac_done        accept strobe / completion pulse
//   spi_start/spi_data        byte launch to spi_master
//   spi_busy/spi_new_data     spi_master status / byte-complete pulse
//   cs1_dac, cs2_reg          active-low chip selects
//   busy                      high outside S_IDLE
//   err                       1-cycle pulse on a per-byte timeout abort
// ---------------------------------------------------------------------------
module dac_reg_spi_sched #(
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int CS_GAP      = 1,
  parameter int SPI_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_valid,
  input  logic [7:0]  reg_data,
  output logic        reg_ready,
  output logic        reg_done,
  input  logic        dac_valid,
  input  logic [15:0] dac_data,
  output logic        dac_ready,
  output logic        dac_done,
  output logic        spi_start,
  output logic [7:0]  spi_data,
  input  logic        spi_busy,
  input  logic        spi_new_data,
  output logic        cs1_dac,
  output logic        cs2_reg,
  output logic        busy,
  output logic        err
);

  // One shared down-counter serves every timed state. Its width must cover
  // the largest interval.
  localparam int MAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int MAX_GT = (CS_GAP > SPI_TIMEOUT) ? CS_GAP : SPI_TIMEOUT;
  localparam int MAX_T  = (MAX_SH > MAX_GT) ? MAX_SH : MAX_GT;
  localparam int TMR_W  = $clog2(MAX_T) + 1;

  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(CS_HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(CS_GAP - 1);
  localparam logic [TMR_W-1:0] TO_LD    = TMR_W'(SPI_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_WAIT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [1:0]       byte_cnt;
  logic [7:0]       lo_byte;
  logic             grant_dac;
  logic             last_dac;
  logic             pick_dac;

  // Arbitration. The DAC wins when it is the only requester. It also wins a
  // tie when the previous grant went to the register. Ready depends only on
  // state and the valids, so the two readys can never be high together.
  always_comb begin
    pick_dac = 1'b0;
    if (dac_valid && (!reg_valid || !last_dac)) begin
      pick_dac = 1'b1;
    end
  end

  assign reg_ready = (state == S_IDLE) && reg_valid && !pick_dac;
  assign dac_ready = (state == S_IDLE) && pick_dac;

  // spi_start is a decode of registered state. This launches the byte in the
  // same cycle spi_busy is seen low, so no cycle is lost.
  assign spi_start = (state == S_START) && !spi_busy;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      tmr       <= '0;
      byte_cnt  <= 2'd0;
      lo_byte   <= 8'h00;
      spi_data  <= 8'h00;
      grant_dac <= 1'b0;
      last_dac  <= 1'b1;
      cs1_dac   <= 1'b1;
      cs2_reg   <= 1'b1;
      reg_done  <= 1'b0;
      dac_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      reg_done <= 1'b0;
      dac_done <= 1'b0;
      err      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (reg_ready || dac_ready) begin
            grant_dac <= pick_dac;
            last_dac  <= pick_dac;
            tmr       <= SETUP_LD;
            state     <= S_SETUP;
            if (pick_dac) begin
              spi_data <= dac_data[15:8];
              lo_byte  <= dac_data[7:0];
              byte_cnt <= 2'd2;
              cs1_dac  <= 1'b0;
            end else begin
              spi_data <= reg_data;
              lo_byte  <= 8'h00;
              byte_cnt <= 2'd1;
              cs2_reg  <= 1'b0;
            end
          end
        end

        S_SETUP: begin
          if (tmr == '0) begin
            state <= S_START;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        S_START: begin
          if (!spi_busy) begin
            tmr   <= TO_LD;
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (spi_new_data) begin
            if (byte_cnt == 2'd1) begin
              byte_cnt <= 2'd0;
              tmr      <= HOLD_LD;
              state    <= S_HOLD;
            end else begin
              byte_cnt <= byte_cnt - 2'd1;
              spi_data <= lo_byte;
              state    <= S_START;
            end
          end else if (tmr == '0) begin
            // Abort: release CS right away. No done pulse follows.
            err     <= 1'b1;
            cs1_dac <= 1'b1;
            cs2_reg <= 1'b1;
            tmr     <= GAP_LD;
            state   <= S_GAP;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        S_HOLD: begin
          if (tmr == '0) begin
            cs1_dac  <= 1'b1;
            cs2_reg  <= 1'b1;
            reg_done <= !grant_dac;
            dac_done <= grant_dac;
            tmr      <= GAP_LD;
            state    <= S_GAP;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        S_GAP: begin
          if (tmr == '0) begin
            state <= S_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        default: begin
          state   <= S_IDLE;
          cs1_dac <= 1'b1;
          cs2_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_reg_spi_sched.sv
// ---------------------------------------------------------------------------
// tb_dac_reg_spi_sched
// Directed bench for dac_reg_spi_sched. A small responder returns
// spi_new_data 16 cycles after each spi_start. A negedge monitor timestamps
// chip-select edges, starts, done and err pulses, and grants. Expected
// cycle offsets were worked out by hand from the default timing parameters.
// ---------------------------------------------------------------------------
module tb_dac_reg_spi_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_valid = 1'b0;
  logic [7:0]  reg_data = 8'h00;
  logic        reg_ready;
  logic        reg_done;
  logic        dac_valid = 1'b0;
  logic [15:0] dac_data = 16'h0000;
  logic        dac_ready;
  logic        dac_done;
  logic        spi_start;
  logic [7:0]  spi_data;
  logic        spi_busy = 1'b0;
  logic        spi_new_data = 1'b0;
  logic        cs1_dac;
  logic        cs2_reg;
  logic        busy;
  logic        err;

  dac_reg_spi_sched dut (
    .clk          (clk),
    .rst          (rst),
    .reg_valid    (reg_valid),
    .reg_data     (reg_data),
    .reg_ready    (reg_ready),
    .reg_done     (reg_done),
    .dac_valid    (dac_valid),
    .dac_data     (dac_data),
    .dac_ready    (dac_ready),
    .dac_done     (dac_done),
    .spi_start    (spi_start),
    .spi_data     (spi_data),
    .spi_busy     (spi_busy),
    .spi_new_data (spi_new_data),
    .cs1_dac      (cs1_dac),
    .cs2_reg      (cs2_reg),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int cyc = 0;
  int resp_due = -1;
  bit resp_en = 1'b1;

  // Monitor state
  bit         grant_q[$];
  int         rdy_cyc_q[$];
  int         st_cyc_q[$];
  logic [7:0] st_dat_q[$];
  int n_both = 0, n_overlap = 0;
  int n_reg_done = 0, n_dac_done = 0, n_err = 0;
  int t_reg_done = -1, t_dac_done = -1, t_err = -1, t_nd = -1;
  logic [1:0] err_cs = 2'b00;
  int t_cs1_fall = -1, t_cs1_rise = -1, n_cs1_fall = 0, n_cs1_rise = 0;
  int t_cs2_fall = -1, t_cs2_rise = -1, n_cs2_fall = 0, n_cs2_rise = 0;
  logic prev_cs1 = 1'b1, prev_cs2 = 1'b1;

  // Cycle counter and SPI responder. Each cycle starts at a posedge, and
  // inputs change 1 time unit after it.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    spi_new_data = resp_en && (cyc == resp_due);
  end

  always @(negedge clk) begin
    if (reg_ready) begin grant_q.push_back(1'b0); rdy_cyc_q.push_back(cyc); end
    if (dac_ready) begin grant_q.push_back(1'b1); rdy_cyc_q.push_back(cyc); end
    if (reg_ready && dac_ready) n_both++;
    if (spi_start) begin
      st_cyc_q.push_back(cyc);
      st_dat_q.push_back(spi_data);
      if (resp_en) resp_due = cyc + 16;
    end
    if (spi_new_data) t_nd = cyc;
    if (reg_done) begin n_reg_done++; t_reg_done = cyc; end
    if (dac_done) begin n_dac_done++; t_dac_done = cyc; end
    if (err) begin n_err++; t_err = cyc; err_cs = {cs1_dac, cs2_reg}; end
    if (prev_cs1 && !cs1_dac) begin t_cs1_fall = cyc; n_cs1_fall++; end
    if (!prev_cs1 && cs1_dac) begin t_cs1_rise = cyc; n_cs1_rise++; end
    if (prev_cs2 && !cs2_reg) begin t_cs2_fall = cyc; n_cs2_fall++; end
    if (!prev_cs2 && cs2_reg) begin t_cs2_rise = cyc; n_cs2_rise++; end
    if (!cs1_dac && !cs2_reg) n_overlap++;
    if (!rst) resp_due = -1;
    prev_cs1 = cs1_dac;
    prev_cs2 = cs2_reg;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  function automatic int get_cnt(input int which);
    case (which)
      0: return n_reg_done;
      1: return n_dac_done;
      2: return n_err;
      3: return st_cyc_q.size();
      default: return grant_q.size();
    endcase
  endfunction

  // Returns once the selected counter reaches target, or after budget cycles.
  task automatic wait_cnt(input int which, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      wait_neg();
      if (get_cnt(which) >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      wait_neg();
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic req(input bit is_dac, input logic [15:0] d, output int t_rdy);
    @(posedge clk);
    #1;
    if (is_dac) begin dac_data = d; dac_valid = 1'b1; end
    else begin reg_data = d[7:0]; reg_valid = 1'b1; end
    t_rdy = -1;
    for (int i = 0; i < 200; i++) begin
      wait_neg();
      if (is_dac ? dac_ready : reg_ready) begin t_rdy = cyc; break; end
    end
    @(posedge clk);
    #1;
    reg_valid = 1'b0;
    dac_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    reg_valid = 1'b0;
    dac_valid = 1'b0;
    spi_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, b, bd, bn, bf, br;
    bit ok;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_neg();
    chk("rst_cs1", cs1_dac, 1);
    chk("rst_cs2", cs2_reg, 1);
    chk("rst_start", spi_start, 0);
    chk("rst_data", spi_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {reg_done, dac_done, err}, 3'b000);

    // 1: single register write
    b = st_cyc_q.size(); bd = n_reg_done; bf = n_cs1_fall;
    req(1'b0, 16'h00A5, t0);
    chk("t1_ready", t0 >= 0, 1);
    wait_cnt(0, bd + 1, 200, ok);
    chk("t1_done_seen", ok, 1);
    chk("t1_cs2_fall", t_cs2_fall, t0 + 1);
    chk("t1_start_cyc", st_cyc_q[b], t0 + 3);
    chk("t1_start_dat", st_dat_q[b], 8'hA5);
    chk("t1_nd_cyc", t_nd, t0 + 19);
    chk("t1_cs2_rise", t_cs2_rise, t_nd + 3);
    chk("t1_done_cyc", t_reg_done, t_nd + 3);
    wait_neg();
    chk("t1_busy_idle", busy, 0);
    chk("t1_one_start", st_cyc_q.size() - b, 1);
    chk("t1_one_done", n_reg_done - bd, 1);
    chk("t1_cs1_untouched", n_cs1_fall - bf, 0);

    // 2: DAC word, MSB first, CS continuous
    b = st_cyc_q.size(); bd = n_dac_done; bf = n_cs1_fall; br = n_cs1_rise;
    req(1'b1, 16'h1234, t0);
    chk("t2_ready", t0 >= 0, 1);
    wait_cnt(1, bd + 1, 200, ok);
    chk("t2_done_seen", ok, 1);
    chk("t2_n_start", st_cyc_q.size() - b, 2);
    chk("t2_byte0", st_dat_q[b], 8'h12);
    chk("t2_byte1", st_dat_q[b+1], 8'h34);
    chk("t2_byte0_cyc", st_cyc_q[b], t0 + 3);
    chk("t2_byte1_cyc", st_cyc_q[b+1], t0 + 20);
    chk("t2_cs1_fall", t_cs1_fall, t0 + 1);
    chk("t2_cs1_rise", t_cs1_rise, t0 + 39);
    chk("t2_cs1_edges", {n_cs1_fall - bf, n_cs1_rise - br}, {32'd1, 32'd1});
    wait_neg();
    chk("t2_one_done", n_dac_done - bd, 1);

    // 3: both requesters held high -> REG, DAC, REG, DAC
    do_reset();
    b = grant_q.size(); bn = n_both; bd = n_dac_done;
    @(posedge clk);
    #1;
    reg_data = 8'h5C; dac_data = 16'hBEEF;
    reg_valid = 1'b1; dac_valid = 1'b1;
    wait_cnt(4, b + 4, 400, ok);
    chk("t3_grants_seen", ok, 1);
    @(posedge clk);
    #1;
    reg_valid = 1'b0; dac_valid = 1'b0;
    wait_cnt(1, bd + 2, 200, ok);
    chk("t3_dac_done", ok, 1);
    wait_idle(20, ok);
    chk("t3_idle", ok, 1);
    chk("t3_order", {grant_q[b], grant_q[b+1], grant_q[b+2], grant_q[b+3]}, 4'b0101);
    chk("t3_gap_reg_dac", rdy_cyc_q[b+1] - rdy_cyc_q[b], 23);
    chk("t3_gap_dac_reg", rdy_cyc_q[b+2] - rdy_cyc_q[b+1], 40);
    chk("t3_no_dual_ready", n_both - bn, 0);

    // 4: timeout, no spi_new_data
    resp_en = 1'b0;
    b = st_cyc_q.size(); bd = n_reg_done; bn = n_err;
    req(1'b0, 16'h003C, t0);
    wait_cnt(2, bn + 1, 200, ok);
    chk("t4_err_seen", ok, 1);
    chk("t4_err_cyc", t_err - st_cyc_q[b], 65);
    chk("t4_err_cs", err_cs, 2'b11);
    wait_neg();
    chk("t4_busy_idle", busy, 0);
    chk("t4_err_once", n_err - bn, 1);
    chk("t4_no_done", n_reg_done - bd, 0);
    resp_en = 1'b1;

    // 5: reset during second DAC byte
    b = st_cyc_q.size(); bd = n_dac_done; bn = n_err;
    req(1'b1, 16'hA55A, t0);
    wait_cnt(3, b + 2, 200, ok);
    chk("t5_second_start", ok, 1);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t5_rst_cs", {cs1_dac, cs2_reg}, 2'b11);
    chk("t5_rst_start", spi_start, 0);
    chk("t5_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) wait_neg();
    chk("t5_no_done", n_dac_done - bd, 0);
    chk("t5_no_err", n_err - bn, 0);
    b = st_cyc_q.size(); bd = n_reg_done;
    req(1'b0, 16'h0077, t0);
    chk("t5_new_accept", t0 >= 0, 1);
    wait_cnt(0, bd + 1, 200, ok);
    chk("t5_new_done", ok, 1);
    chk("t5_new_byte", st_dat_q[b], 8'h77);

    // 6: spi_busy holds off spi_start for 10 START cycles
    wait_idle(20, ok);
    spi_busy = 1'b1;
    b = st_cyc_q.size(); bd = n_reg_done;
    req(1'b0, 16'h00C3, t0);
    repeat (12) @(posedge clk);
    #1;
    spi_busy = 1'b0;
    wait_cnt(0, bd + 1, 200, ok);
    chk("t6_done_seen", ok, 1);
    chk("t6_one_start", st_cyc_q.size() - b, 1);
    chk("t6_start_cyc", st_cyc_q[b], t0 + 13);
    chk("t6_start_dat", st_dat_q[b], 8'hC3);

    chk("cs_never_overlap", n_overlap, 0);
    chk("ready_never_dual", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
